// File: rtl/mem_rd_arb.sv
// mem_rd_arb: round-robin arbiter sharing one memory read port among NREQ requesters,
// with per-port holding registers, same-address merging and an in-flight read cap.
module mem_rd_arb #(
    parameter int NREQ    = 3,
    parameter int MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_re,
    input  logic [16*NREQ-1:0] req_raddr,
    output logic [NREQ-1:0]    req_full,
    output logic [NREQ-1:0]    req_gnt,
    output logic               mem_re,
    output logic [15:0]        mem_raddr,
    input  logic               mem_ready,
    output logic               idle,
    output logic               err
);
    localparam int PW = $clog2(NREQ);
    localparam logic [3:0] MAX_C = 4'(MAX_OUT);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [NREQ-1:0] pend_v_q, pend_v_d;
    logic [15:0]     pend_a_q [NREQ];
    logic [15:0]     pend_a_d [NREQ];
    logic [PW-1:0]   rr_q, rr_d;
    logic [3:0]      out_cnt_q, out_cnt_d;
    logic [7:0]      grace_q, grace_d;
    logic            err_q, err_d;
    logic            mem_re_q, mem_re_d;
    logic [15:0]     mem_raddr_q, mem_raddr_d;
    logic [NREQ-1:0] req_gnt_q, req_gnt_d;
    logic [PW-1:0]   idx, win;
    logic [NREQ-1:0] hit;
    logic            found, issue, overrun, underflow;

    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_q) + k) % NREQ);
            if (!found && pend_v_q[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
        issue = |pend_v_q && (out_cnt_q < MAX_C || mem_ready);
        overrun = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            hit[j] = pend_v_q[j] && pend_a_q[j] == pend_a_q[win];
            pend_v_d[j] = (pend_v_q[j] && !(issue && hit[j])) || req_re[j];
            pend_a_d[j] = (req_re[j] && (!pend_v_q[j] || (issue && hit[j])))
                        ? req_raddr[16*j +: 16] : pend_a_q[j];
            overrun = overrun || (req_re[j] && pend_v_q[j] && !(issue && hit[j]));
        end
        // A response with nothing counted is only a protocol error once the post-reset window has expired
        underflow = mem_ready && !issue && out_cnt_q == 4'd0 && grace_q == 8'd0;
        out_cnt_d = (issue && !mem_ready) ? out_cnt_q + 4'd1
                  : (!issue && mem_ready && out_cnt_q != 4'd0) ? out_cnt_q - 4'd1 : out_cnt_q;
        err_d = err_q || overrun || underflow;
        rr_d = issue ? ((win == LAST) ? '0 : win + 1'b1) : rr_q;
        mem_re_d = issue;
        mem_raddr_d = issue ? pend_a_q[win] : 16'h0000;
        req_gnt_d = issue ? hit : '0;
        grace_d = (grace_q != 8'd0) ? grace_q - 8'd1 : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_v_q    <= '0;
            pend_a_q    <= '{default: '0};
            rr_q        <= '0;
            out_cnt_q   <= '0;
            grace_q     <= 8'd128;
            err_q       <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_raddr_q <= '0;
            req_gnt_q   <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_a_q    <= pend_a_d;
            rr_q        <= rr_d;
            out_cnt_q   <= out_cnt_d;
            grace_q     <= grace_d;
            err_q       <= err_d;
            mem_re_q    <= mem_re_d;
            mem_raddr_q <= mem_raddr_d;
            req_gnt_q   <= req_gnt_d;
        end
    end

    assign req_full  = pend_v_q;
    assign req_gnt   = req_gnt_q;
    assign mem_re    = mem_re_q;
    assign mem_raddr = mem_raddr_q;
    assign err       = err_q;
    assign idle      = !(|pend_v_q) && out_cnt_q == 4'd0 && !mem_re_q;
endmodule

// File: tb/tb_mem_rd_arb.sv
// tb_mem_rd_arb: directed checks of mem_rd_arb with NREQ=3, MAX_OUT=4.
module tb_mem_rd_arb;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_re;
  logic [47:0] req_raddr;
  logic [2:0]  req_full;
  logic [2:0]  req_gnt;
  logic        mem_re;
  logic [15:0] mem_raddr;
  logic        mem_ready;
  logic        idle;
  logic        err;
  int          checks = 0;
  int          errors = 0;
  mem_rd_arb #(.NREQ(3), .MAX_OUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_re(req_re), .req_raddr(req_raddr),
    .req_full(req_full), .req_gnt(req_gnt), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_ready(mem_ready), .idle(idle), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0; req_re = '0; req_raddr = '0; mem_ready = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_raddr", mem_raddr, 16'h0000);
    chk("rst_gnt", req_gnt, 3'b000);
    chk("rst_full", req_full, 3'b000);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err, 1'b0);
    req_raddr[15:0] = 16'h0040; req_re = 3'b001;
    tick; req_re = '0;
    chk("single_full", req_full, 3'b001);
    chk("single_no_early_re", mem_re, 1'b0);
    tick;
    chk("single_re", mem_re, 1'b1);
    chk("single_raddr", mem_raddr, 16'h0040);
    chk("single_gnt", req_gnt, 3'b001);
    chk("single_full_clr", req_full, 3'b000);
    chk("single_busy", idle, 1'b0);
    tick;
    chk("single_re_drop", mem_re, 1'b0);
    chk("single_inflight", idle, 1'b0);
    mem_ready = 1'b1; tick; mem_ready = 1'b0;
    chk("single_idle", idle, 1'b1);
    chk("single_err", err, 1'b0);
    reset_n = 1'b0; tick; reset_n = 1'b1;
    req_raddr = {16'd30, 16'd20, 16'd10}; req_re = 3'b111;
    tick; req_re = '0;
    chk("rr_full", req_full, 3'b111);
    tick;
    chk("rr_a0", mem_raddr, 16'd10);
    chk("rr_g0", req_gnt, 3'b001);
    tick;
    chk("rr_a1", mem_raddr, 16'd20);
    chk("rr_g1", req_gnt, 3'b010);
    tick;
    chk("rr_a2", mem_raddr, 16'd30);
    chk("rr_g2", req_gnt, 3'b100);
    chk("rr_full_clr", req_full, 3'b000);
    tick;
    chk("rr_re_end", mem_re, 1'b0);
    chk("rr_busy", idle, 1'b0);
    mem_ready = 1'b1; tick; tick; tick; mem_ready = 1'b0;
    chk("rr_idle", idle, 1'b1);
    req_raddr = {16'd0, 16'd60, 16'd50}; req_re = 3'b011;
    tick; req_re = '0;
    tick;
    chk("rr2_a0", mem_raddr, 16'd50);
    chk("rr2_g0", req_gnt, 3'b001);
    tick;
    chk("rr2_a1", mem_raddr, 16'd60);
    chk("rr2_g1", req_gnt, 3'b010);
    mem_ready = 1'b1; tick; tick; mem_ready = 1'b0;
    chk("rr2_idle", idle, 1'b1);
    req_raddr = {16'h0100, 16'h0100, 16'h0000}; req_re = 3'b110;
    tick; req_re = '0;
    chk("merge_full", req_full, 3'b110);
    tick;
    chk("merge_re", mem_re, 1'b1);
    chk("merge_raddr", mem_raddr, 16'h0100);
    chk("merge_gnt", req_gnt, 3'b110);
    chk("merge_full_clr", req_full, 3'b000);
    tick;
    chk("merge_single_read", mem_re, 1'b0);
    mem_ready = 1'b1; tick; mem_ready = 1'b0;
    chk("merge_count_once", idle, 1'b1);
    chk("merge_err", err, 1'b0);
    req_raddr = {16'h1002, 16'h1001, 16'h1000}; req_re = 3'b111;
    tick;
    chk("cap_full0", req_full, 3'b111);
    req_re = 3'b001; req_raddr[15:0] = 16'h1003;
    tick;
    chk("cap_a0", mem_raddr, 16'h1000);
    chk("cap_g0", req_gnt, 3'b001);
    chk("cap_recapture", req_full, 3'b111);
    req_re = 3'b010; req_raddr[31:16] = 16'h1004;
    tick; req_re = '0;
    chk("cap_a1", mem_raddr, 16'h1001);
    chk("cap_full1", req_full, 3'b111);
    tick;
    chk("cap_a2", mem_raddr, 16'h1002);
    chk("cap_full2", req_full, 3'b011);
    tick;
    chk("cap_a3", mem_raddr, 16'h1003);
    chk("cap_re3", mem_re, 1'b1);
    chk("cap_full3", req_full, 3'b010);
    tick;
    chk("cap_stall", mem_re, 1'b0);
    chk("cap_stall_full", req_full, 3'b010);
    tick; tick;
    chk("cap_stall_hold", mem_re, 1'b0);
    mem_ready = 1'b1; tick; mem_ready = 1'b0;
    chk("cap_a4_re", mem_re, 1'b1);
    chk("cap_a4", mem_raddr, 16'h1004);
    chk("cap_g4", req_gnt, 3'b010);
    chk("cap_full4", req_full, 3'b000);
    req_raddr[47:32] = 16'h1005; req_re = 3'b100;
    tick; req_re = '0;
    chk("cap_full5", req_full, 3'b100);
    tick;
    chk("cap_still_max", mem_re, 1'b0);
    mem_ready = 1'b1; tick; mem_ready = 1'b0;
    chk("cap_a5", mem_raddr, 16'h1005);
    chk("cap_g5", req_gnt, 3'b100);
    chk("cap_err", err, 1'b0);
    req_raddr[15:0] = 16'h0005; req_re = 3'b001;
    tick;
    chk("ovr_full", req_full, 3'b001);
    chk("ovr_no_re", mem_re, 1'b0);
    req_raddr[15:0] = 16'h0006;
    tick; req_re = '0;
    chk("ovr_err", err, 1'b1);
    chk("ovr_keep", req_full, 3'b001);
    mem_ready = 1'b1; tick;
    chk("ovr_re", mem_re, 1'b1);
    chk("ovr_addr_kept", mem_raddr, 16'h0005);
    chk("ovr_gnt", req_gnt, 3'b001);
    chk("ovr_full_clr", req_full, 3'b000);
    tick;
    chk("ovr_dropped", mem_re, 1'b0);
    tick; tick;
    chk("ovr_drain_busy", idle, 1'b0);
    tick; mem_ready = 1'b0;
    chk("ovr_drain_idle", idle, 1'b1);
    req_raddr = {16'h0000, 16'h0201, 16'h0200}; req_re = 3'b011;
    tick; req_re = '0;
    tick; tick;
    req_raddr[47:32] = 16'h0202; req_re = 3'b100;
    tick; req_re = '0;
    chk("mid_full", req_full, 3'b100);
    chk("mid_busy", idle, 1'b0);
    chk("mid_err_sticky", err, 1'b1);
    reset_n = 1'b0; tick; reset_n = 1'b1;
    chk("mid_rst_re", mem_re, 1'b0);
    chk("mid_rst_raddr", mem_raddr, 16'h0000);
    chk("mid_rst_gnt", req_gnt, 3'b000);
    chk("mid_rst_full", req_full, 3'b000);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_err", err, 1'b0);
    mem_ready = 1'b1; tick; mem_ready = 1'b0; tick;
    mem_ready = 1'b1; tick; mem_ready = 1'b0;
    chk("late_ready_err", err, 1'b0);
    chk("late_ready_idle", idle, 1'b1);
    req_raddr[15:0] = 16'h0300; req_re = 3'b001;
    tick; req_re = '0;
    tick;
    chk("post_rst_addr", mem_raddr, 16'h0300);
    mem_ready = 1'b1; tick; mem_ready = 1'b0;
    chk("post_rst_cnt_zero", idle, 1'b1);
    repeat (140) tick;
    chk("window_err_clear", err, 1'b0);
    mem_ready = 1'b1; tick; mem_ready = 1'b0;
    chk("underflow_err", err, 1'b1);
    chk("underflow_idle", idle, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
